// File: rtl/sp_tracker_pkg.sv
// Shared types and helpers for the dual-axis sun tracker: state encodings,
// direction codes, widths and the saturating position step.
package sp_tracker_pkg;

  localparam int POS_W = 8;
  localparam int V_W   = 12;

  localparam logic [POS_W-1:0] POS_CENTRE = 8'd128;

  typedef enum logic [2:0] {
    STAT_MANUAL  = 3'b000,
    STAT_TRACK_H = 3'b001,
    STAT_TRACK_V = 3'b010,
    STAT_HOLD    = 3'b100
  } stat_e;

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic inc, input logic dec);
    step_pos = pos;
    if (inc && (pos != '1))
      step_pos = pos + POS_W'(1);
    else if (dec && (pos != '0))
      step_pos = pos - POS_W'(1);
  endfunction

  // Exactly one of the two buttons gives its code (a -> 01, b -> 10); none or both stops.
  function automatic logic [1:0] jog_dir(input logic a, input logic b);
    return (a ^ b) ? {b, a} : DIR_STOP;
  endfunction

  function automatic logic [1:0] flip_dir(input logic [1:0] d);
    return {d[0], d[1]};
  endfunction

endpackage

// File: rtl/sp_tracker_core_servo_pwm.sv
// One servo PWM channel: free-running frame counter, registered pulse compare
// and a one-cycle tick on the cycle the counter has wrapped to zero.
module servo_pwm
  import sp_tracker_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 2_000_000,
  parameter int unsigned PULSE_MIN  = 100_000,
  parameter int unsigned PULSE_STEP = 390
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [POS_W-1:0] pos,
  output logic             pwm,
  output logic             tick
);

  localparam int CNT_W = $clog2(PWM_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      high_len;
  logic             last;

  assign high_len = PULSE_MIN + 32'(pos) * PULSE_STEP;
  assign last     = (cnt == CNT_W'(PWM_PERIOD - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      pwm  <= 1'b0;
      tick <= 1'b0;
    end else begin
      cnt  <= last ? '0 : cnt + CNT_W'(1);
      tick <= last;
      pwm  <= (32'(cnt) < high_len);
    end
  end

endmodule

// File: rtl/sp_tracker_core.sv
// Dual-axis sun tracker: button synchronisers, manual jog / perturb-and-observe
// FSM and the pan/tilt position registers driving two servo PWM channels.
module sp_tracker_core
  import sp_tracker_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 2_000_000,
  parameter int unsigned PULSE_MIN  = 100_000,
  parameter int unsigned PULSE_STEP = 390,
  parameter int unsigned HYST       = 16,
  parameter int unsigned DROP       = 256
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           BTN_L,
  input  logic           BTN_R,
  input  logic           BTN_U,
  input  logic           BTN_D,
  input  logic           BTN_C,
  input  logic [V_W-1:0] V_in,
  output logic [V_W-1:0] max_V_in,
  output logic [1:0]     direction_lr,
  output logic [1:0]     direction_ud,
  output logic           servo_l,
  output logic           servo_r,
  output logic           servo_u,
  output logic           servo_d,
  output logic           SERVO_H,
  output logic           SERVO_V,
  output logic [2:0]     STAT
);

  localparam logic [V_W:0] HYST_X = (V_W + 1)'(HYST);
  localparam logic [V_W:0] DROP_X = (V_W + 1)'(DROP);

  logic [4:0] btn_meta, btn_sync;
  logic       c_prev, c_edge;

  stat_e            state, state_n;
  logic [POS_W-1:0] pos_h, pos_h_n, pos_v, pos_v_n, mv_h, mv_v;
  logic [V_W-1:0]   max_v, max_v_n;
  logic [1:0]       dir_lr, dir_lr_n, dir_ud, dir_ud_n;
  logic [1:0]       cnt_rev, cnt_rev_n;
  logic             tick, tick_h, tick_v;
  logic             gain, worse, dropped;

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_meta <= '0;
      btn_sync <= '0;
      c_prev   <= 1'b0;
    end else begin
      btn_meta <= {BTN_C, BTN_D, BTN_U, BTN_R, BTN_L};
      btn_sync <= btn_meta;
      c_prev   <= btn_sync[4];
    end
  end

  assign c_edge  = btn_sync[4] & ~c_prev;
  assign mv_h    = step_pos(pos_h, dir_lr[1], dir_lr[0]);
  assign mv_v    = step_pos(pos_v, dir_ud[0], dir_ud[1]);
  assign gain    = (V_in > max_v);
  assign worse   = (({1'b0, V_in} + HYST_X) < {1'b0, max_v});
  assign dropped = (({1'b0, V_in} + DROP_X) < {1'b0, max_v});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= STAT_MANUAL;
      pos_h   <= POS_CENTRE;
      pos_v   <= POS_CENTRE;
      max_v   <= '0;
      dir_lr  <= DIR_STOP;
      dir_ud  <= DIR_STOP;
      cnt_rev <= '0;
    end else begin
      state   <= state_n;
      pos_h   <= pos_h_n;
      pos_v   <= pos_v_n;
      max_v   <= max_v_n;
      dir_lr  <= dir_lr_n;
      dir_ud  <= dir_ud_n;
      cnt_rev <= cnt_rev_n;
    end
  end

  // A centre-button edge always beats a coincident tick, so no move happens that frame.
  always_comb begin
    state_n   = state;
    pos_h_n   = pos_h;
    pos_v_n   = pos_v;
    max_v_n   = max_v;
    dir_lr_n  = dir_lr;
    dir_ud_n  = dir_ud;
    cnt_rev_n = cnt_rev;
    unique case (state)
      STAT_MANUAL: begin
        dir_lr_n = jog_dir(btn_sync[0], btn_sync[1]);
        dir_ud_n = jog_dir(btn_sync[2], btn_sync[3]);
        if (c_edge) begin
          state_n   = STAT_TRACK_H;
          max_v_n   = V_in;
          dir_lr_n  = DIR_RIGHT;
          dir_ud_n  = DIR_STOP;
          cnt_rev_n = '0;
        end else if (tick) begin
          pos_h_n = mv_h;
          pos_v_n = mv_v;
        end
      end
      STAT_TRACK_H, STAT_TRACK_V: begin
        if (c_edge) begin
          state_n   = STAT_MANUAL;
          dir_lr_n  = DIR_STOP;
          dir_ud_n  = DIR_STOP;
          cnt_rev_n = '0;
        end else if (tick) begin
          if (gain)
            max_v_n = V_in;
          if (state == STAT_TRACK_H) begin
            pos_h_n = mv_h;
            if (worse || (mv_h == '0) || (mv_h == '1)) begin
              if (cnt_rev == 2'd1) begin
                state_n   = STAT_TRACK_V;
                dir_lr_n  = DIR_STOP;
                dir_ud_n  = DIR_UP;
                cnt_rev_n = '0;
              end else begin
                dir_lr_n  = flip_dir(dir_lr);
                cnt_rev_n = cnt_rev + 2'd1;
              end
            end
          end else begin
            pos_v_n = mv_v;
            if (worse || (mv_v == '0) || (mv_v == '1)) begin
              if (cnt_rev == 2'd1) begin
                state_n   = STAT_HOLD;
                dir_ud_n  = DIR_STOP;
                cnt_rev_n = '0;
              end else begin
                dir_ud_n  = flip_dir(dir_ud);
                cnt_rev_n = cnt_rev + 2'd1;
              end
            end
          end
        end
      end
      STAT_HOLD: begin
        if (c_edge) begin
          state_n   = STAT_MANUAL;
          dir_lr_n  = DIR_STOP;
          dir_ud_n  = DIR_STOP;
          cnt_rev_n = '0;
        end else if (tick && dropped) begin
          state_n   = STAT_TRACK_H;
          max_v_n   = V_in;
          dir_lr_n  = DIR_RIGHT;
          cnt_rev_n = '0;
        end
      end
      default: state_n = STAT_MANUAL;
    endcase
  end

  servo_pwm #(.PWM_PERIOD(PWM_PERIOD), .PULSE_MIN(PULSE_MIN), .PULSE_STEP(PULSE_STEP)) u_pwm_h (
    .CLK (CLK),
    .RST (RST),
    .pos (pos_h),
    .pwm (SERVO_H),
    .tick(tick_h)
  );

  servo_pwm #(.PWM_PERIOD(PWM_PERIOD), .PULSE_MIN(PULSE_MIN), .PULSE_STEP(PULSE_STEP)) u_pwm_v (
    .CLK (CLK),
    .RST (RST),
    .pos (pos_v),
    .pwm (SERVO_V),
    .tick(tick_v)
  );

  // Both counters leave reset together, so their ticks coincide.
  assign tick = tick_h & tick_v;

  assign max_V_in     = max_v;
  assign direction_lr = dir_lr;
  assign direction_ud = dir_ud;
  assign servo_l      = (dir_lr == DIR_LEFT);
  assign servo_r      = (dir_lr == DIR_RIGHT);
  assign servo_u      = (dir_ud == DIR_UP);
  assign servo_d      = (dir_ud == DIR_DOWN);
  assign STAT         = state;

endmodule

// File: tb/tb_sp_tracker_core.sv
// Directed bench for sp_tracker_core with a short 400-cycle servo frame.
module tb_sp_tracker_core;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_L    = 5'b00001;
  localparam logic [4:0] B_R    = 5'b00010;
  localparam logic [4:0] B_U    = 5'b00100;
  localparam logic [4:0] B_D    = 5'b01000;
  localparam logic [4:0] B_C    = 5'b10000;
  localparam int FRAME = 400;

  logic        CLK = 1'b0;
  logic        RST;
  logic        BTN_L, BTN_R, BTN_U, BTN_D, BTN_C;
  logic [11:0] V_in;
  logic [11:0] max_V_in;
  logic [1:0]  direction_lr, direction_ud;
  logic        servo_l, servo_r, servo_u, servo_d;
  logic        SERVO_H, SERVO_V;
  logic [2:0]  STAT;

  int n_compared = 0;
  int n_mismatched = 0;
  int w, p;

  sp_tracker_core #(
    .PWM_PERIOD(400), .PULSE_MIN(20), .PULSE_STEP(1), .HYST(16), .DROP(256)
  ) dut (
    .CLK(CLK), .RST(RST),
    .BTN_L(BTN_L), .BTN_R(BTN_R), .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_C(BTN_C),
    .V_in(V_in), .max_V_in(max_V_in),
    .direction_lr(direction_lr), .direction_ud(direction_ud),
    .servo_l(servo_l), .servo_r(servo_r), .servo_u(servo_u), .servo_d(servo_d),
    .SERVO_H(SERVO_H), .SERVO_V(SERVO_V), .STAT(STAT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] btns, input logic [11:0] v);
    {BTN_C, BTN_D, BTN_U, BTN_R, BTN_L} = btns;
    V_in = v;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pressCentre(input logic [11:0] v);
    applyStimulus(B_C, v);
    waitCycles(4);
    applyStimulus(B_NONE, v);
    waitCycles(10);
  endtask

  // Width and period of the next full pulse on the chosen servo pin; returns just after the following rise.
  task automatic measurePulse(input string tag, input bit sel_v, output int width, output int period);
    bit prev, cur, done;
    int guard;
    width = 0;
    period = 0;
    done = 1'b0;
    guard = 0;
    prev = sel_v ? SERVO_V : SERVO_H;
    while (!done && guard < 2000) begin
      @(negedge CLK);
      guard++;
      cur = sel_v ? SERVO_V : SERVO_H;
      if (!prev && cur) done = 1'b1;
      prev = cur;
    end
    if (done) begin
      width = 1;
      period = 1;
      done = 1'b0;
      while (!done && guard < 2000) begin
        @(negedge CLK);
        guard++;
        cur = sel_v ? SERVO_V : SERVO_H;
        if (!prev && cur) done = 1'b1;
        else begin
          period++;
          if (cur) width++;
        end
        prev = cur;
      end
    end
    checkOutput({tag, "_timeout"}, 32'(!done), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(B_NONE, 12'd0);
    waitCycles(2);
    checkOutput("rst_stat", 32'(STAT), 32'd0);
    checkOutput("rst_max", 32'(max_V_in), 32'd0);
    checkOutput("rst_dirs", 32'({direction_lr, direction_ud}), 32'd0);
    checkOutput("rst_flags", 32'({servo_l, servo_r, servo_u, servo_d}), 32'd0);
    checkOutput("rst_pins", 32'({SERVO_H, SERVO_V}), 32'd0);
    RST = 1'b0;

    measurePulse("rst_h", 1'b0, w, p);
    checkOutput("rst_h_width", 32'(w), 32'd148);
    checkOutput("rst_h_period", 32'(p), 32'd400);
    measurePulse("rst_v", 1'b1, w, p);
    checkOutput("rst_v_width", 32'(w), 32'd148);
    waitCycles(100);

    $display("[TB] manual jog");
    applyStimulus(B_R, 12'd0);
    waitCycles(10 * FRAME);
    checkOutput("jog_r_dir", 32'(direction_lr), 32'd2);
    checkOutput("jog_r_flags", 32'({servo_l, servo_r}), 32'b01);
    applyStimulus(B_NONE, 12'd0);
    waitCycles(10);
    checkOutput("rel_r_flag", 32'(servo_r), 32'd0);
    checkOutput("rel_r_dir", 32'(direction_lr), 32'd0);
    measurePulse("jog_r", 1'b0, w, p);
    checkOutput("jog_r_width", 32'(w), 32'd158);
    waitCycles(100);

    applyStimulus(B_U, 12'd0);
    waitCycles(3 * FRAME);
    checkOutput("jog_u_dir", 32'(direction_ud), 32'd1);
    checkOutput("jog_u_flag", 32'(servo_u), 32'd1);
    applyStimulus(B_NONE, 12'd0);
    waitCycles(10);
    measurePulse("jog_u", 1'b1, w, p);
    checkOutput("jog_u_width", 32'(w), 32'd151);
    waitCycles(100);

    applyStimulus(B_D, 12'd0);
    waitCycles(2 * FRAME);
    checkOutput("jog_d_dir", 32'(direction_ud), 32'd2);
    checkOutput("jog_d_flag", 32'(servo_d), 32'd1);
    applyStimulus(B_NONE, 12'd0);
    waitCycles(10);
    measurePulse("jog_d", 1'b1, w, p);
    checkOutput("jog_d_width", 32'(w), 32'd149);
    waitCycles(100);

    applyStimulus(B_L, 12'd0);
    waitCycles(159 * FRAME);
    checkOutput("jog_l_dir", 32'(direction_lr), 32'd1);
    checkOutput("jog_l_flags", 32'({servo_l, servo_r}), 32'b10);
    applyStimulus(B_NONE, 12'd0);
    waitCycles(10);
    measurePulse("jog_l_sat", 1'b0, w, p);
    checkOutput("jog_l_sat_width", 32'(w), 32'd20);
    waitCycles(100);

    applyStimulus(B_L | B_R, 12'd0);
    waitCycles(10);
    checkOutput("jog_lr_dir", 32'(direction_lr), 32'd0);
    checkOutput("jog_lr_flags", 32'({servo_l, servo_r}), 32'd0);
    waitCycles(2 * FRAME);
    applyStimulus(B_NONE, 12'd0);
    waitCycles(10);
    measurePulse("jog_lr", 1'b0, w, p);
    checkOutput("jog_lr_width", 32'(w), 32'd20);
    waitCycles(100);

    $display("[TB] auto tracking");
    pressCentre(12'd1000);
    checkOutput("start_stat", 32'(STAT), 32'd1);
    checkOutput("start_max", 32'(max_V_in), 32'd1000);
    checkOutput("start_dir_lr", 32'(direction_lr), 32'd2);
    checkOutput("start_dir_ud", 32'(direction_ud), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(B_NONE, 12'(1000 + 50 * i));
      waitCycles(FRAME);
      checkOutput($sformatf("climb%0d_max", i), 32'(max_V_in), 32'(1000 + 50 * i));
      checkOutput($sformatf("climb%0d_dir", i), 32'(direction_lr), 32'd2);
    end
    measurePulse("climb", 1'b0, w, p);
    checkOutput("climb_width", 32'(w), 32'd25);
    checkOutput("climb_stat", 32'(STAT), 32'd1);
    waitCycles(100);

    applyStimulus(B_NONE, 12'd1100);
    waitCycles(FRAME);
    checkOutput("rev1_dir", 32'(direction_lr), 32'd1);
    checkOutput("rev1_stat", 32'(STAT), 32'd1);
    checkOutput("rev1_max", 32'(max_V_in), 32'd1200);
    waitCycles(FRAME);
    checkOutput("rev2_stat", 32'(STAT), 32'd2);
    checkOutput("rev2_dirs", 32'({direction_lr, direction_ud}), 32'b0001);
    checkOutput("rev2_flag_u", 32'(servo_u), 32'd1);
    waitCycles(FRAME);
    checkOutput("rev3_stat", 32'(STAT), 32'd2);
    checkOutput("rev3_dir_ud", 32'(direction_ud), 32'd2);
    checkOutput("rev3_flag_d", 32'(servo_d), 32'd1);
    waitCycles(FRAME);
    checkOutput("rev4_stat", 32'(STAT), 32'd4);
    checkOutput("rev4_dirs", 32'({direction_lr, direction_ud}), 32'd0);
    checkOutput("rev4_max", 32'(max_V_in), 32'd1200);

    applyStimulus(B_NONE, 12'd1000);
    waitCycles(FRAME);
    checkOutput("hold_200_stat", 32'(STAT), 32'd4);
    applyStimulus(B_NONE, 12'd944);
    waitCycles(FRAME);
    checkOutput("hold_256_stat", 32'(STAT), 32'd4);
    applyStimulus(B_NONE, 12'd900);
    waitCycles(FRAME);
    checkOutput("retrack_stat", 32'(STAT), 32'd1);
    checkOutput("retrack_max", 32'(max_V_in), 32'd900);
    checkOutput("retrack_dir", 32'(direction_lr), 32'd2);

    applyStimulus(B_NONE, 12'd884);
    waitCycles(FRAME);
    checkOutput("hyst_edge_dir", 32'(direction_lr), 32'd2);
    checkOutput("hyst_edge_max", 32'(max_V_in), 32'd900);
    applyStimulus(B_NONE, 12'd883);
    waitCycles(FRAME);
    checkOutput("hyst_over_dir", 32'(direction_lr), 32'd1);

    pressCentre(12'd883);
    checkOutput("c_auto_stat", 32'(STAT), 32'd0);
    checkOutput("c_auto_dirs", 32'({direction_lr, direction_ud}), 32'd0);
    checkOutput("c_auto_max", 32'(max_V_in), 32'd900);

    pressCentre(12'd1000);
    checkOutput("c_man_stat", 32'(STAT), 32'd1);
    checkOutput("c_man_max", 32'(max_V_in), 32'd1000);
    applyStimulus(B_NONE, 12'd800);
    waitCycles(2 * FRAME);
    checkOutput("tv_again_stat", 32'(STAT), 32'd2);
    checkOutput("tv_again_dir", 32'(direction_ud), 32'd1);
    checkOutput("tv_again_pin_v", 32'(SERVO_V), 32'd1);

    $display("[TB] reset during tilt tracking");
    RST = 1'b1;
    waitCycles(1);
    checkOutput("midrst_stat", 32'(STAT), 32'd0);
    checkOutput("midrst_max", 32'(max_V_in), 32'd0);
    checkOutput("midrst_dirs", 32'({direction_lr, direction_ud}), 32'd0);
    checkOutput("midrst_flags", 32'({servo_l, servo_r, servo_u, servo_d}), 32'd0);
    checkOutput("midrst_pins", 32'({SERVO_H, SERVO_V}), 32'd0);
    waitCycles(1);
    RST = 1'b0;
    measurePulse("midrst_h", 1'b0, w, p);
    checkOutput("midrst_h_width", 32'(w), 32'd148);
    checkOutput("midrst_h_period", 32'(p), 32'd400);
    measurePulse("midrst_v", 1'b1, w, p);
    checkOutput("midrst_v_width", 32'(w), 32'd148);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
